// File: rtl/tpg_frame_sequencer.sv
// rtl/tpg_frame_sequencer.sv - test-pattern frame/line timing sequencer with frame-boundary config shadowing
// Optional TPG_SEQ_CFG_CHECK_EN: reject configs whose period cannot hold the frame, flagged on cfg_err.
module tpg_frame_sequencer #(
    parameter int DEF_WIDTH  = 240,
    parameter int DEF_HEIGHT = 180,
    parameter int DEF_HBLANK = 1330,
    parameter int DEF_PERIOD = 3325000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic [11:0] cfg_width,
    input  logic [11:0] cfg_height,
    input  logic [15:0] cfg_hblank,
    input  logic [31:0] cfg_period,
    input  logic [15:0] cfg_frames,
    input  logic        cfg_valid,
    output logic        frame_valid,
    output logic        line_valid,
    output logic [11:0] pixel_x,
    output logic [11:0] line_y,
    output logic        frame_start,
    output logic        frame_done,
    output logic        busy,
    output logic        cfg_pending,
    output logic [15:0] frames_sent
`ifdef TPG_SEQ_CFG_CHECK_EN
    ,
    output logic        cfg_err
`endif
);

    typedef enum logic [2:0] {IDLE, ARM, LINE_ACT, LINE_BLANK, FRAME_GAP} state_t;
    state_t state, state_nxt;

    logic [11:0] sh_width, sh_height, pd_width, pd_height, cur_width, cur_height;
    logic [15:0] sh_hblank, pd_hblank, cur_hblank, sh_frames, pd_frames, blank_cnt;
    logic [31:0] sh_period, pd_period, cur_period, period_cnt;
    logic        stop_seen, finish_q;
    logic        last_pix, last_line, last_blank, period_hit, frames_hit, finish_now;
    logic        start_acc, launch, apply, cfg_shape_ok, cfg_fits, cfg_ok;

    assign last_pix   = pixel_x == cur_width - 12'd1;
    assign last_line  = line_y == cur_height - 12'd1;
    assign last_blank = blank_cnt == cur_hblank - 16'd1;
    assign period_hit = ({1'b0, period_cnt} + 33'd1) >= {1'b0, cur_period};
    assign frames_hit = (sh_frames != 16'd0) && (frames_sent + 16'd1 == sh_frames);
    assign finish_now = stop_seen || stop || frames_hit;
    assign start_acc  = (state == IDLE) && start;
    assign launch     = ((state == ARM) || (state == FRAME_GAP)) && (state_nxt == LINE_ACT);

    assign line_valid  = state == LINE_ACT;
    assign frame_valid = line_valid || ((state == LINE_BLANK) && !last_line);
    assign frame_start = line_valid && (pixel_x == 12'd0) && (line_y == 12'd0);
    assign frame_done  = line_valid && last_pix && last_line;
    assign busy        = state != IDLE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // The trailing gap always lasts at least one cycle, which clamps short periods.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (start) state_nxt = ARM;
            ARM:      state_nxt = LINE_ACT;
            LINE_ACT: begin
                if (last_pix) begin
                    if (cur_hblank != 16'd0) state_nxt = LINE_BLANK;
                    else if (!last_line)     state_nxt = LINE_ACT;
                    else                     state_nxt = finish_now ? IDLE : FRAME_GAP;
                end
            end
            LINE_BLANK: begin
                if (last_blank) begin
                    if (!last_line) state_nxt = LINE_ACT;
                    else            state_nxt = (finish_q || stop_seen || stop) ? IDLE : FRAME_GAP;
                end
            end
            FRAME_GAP: begin
                if (stop_seen || stop) state_nxt = IDLE;
                else if (period_hit)   state_nxt = LINE_ACT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_x     <= 12'd0;
            line_y      <= 12'd0;
            blank_cnt   <= 16'd0;
            period_cnt  <= 32'd0;
            frames_sent <= 16'd0;
            stop_seen   <= 1'b0;
            finish_q    <= 1'b0;
            cur_width   <= 12'(DEF_WIDTH);
            cur_height  <= 12'(DEF_HEIGHT);
            cur_hblank  <= 16'(DEF_HBLANK);
            cur_period  <= 32'(DEF_PERIOD);
        end else begin
            pixel_x   <= (line_valid && (state_nxt == LINE_ACT) && !last_pix) ? pixel_x + 12'd1 : 12'd0;
            blank_cnt <= ((state == LINE_BLANK) && (state_nxt == LINE_BLANK)) ? blank_cnt + 16'd1 : 16'd0;

            if ((state_nxt == IDLE) || launch)
                line_y <= 12'd0;
            else if ((state_nxt == LINE_ACT) && ((state == LINE_BLANK) || (line_valid && last_pix)))
                line_y <= line_y + 12'd1;

            if (frame_start)  period_cnt <= 32'd1;
            else if (busy)    period_cnt <= period_cnt + 32'd1;

            if (start_acc)       frames_sent <= 16'd0;
            else if (frame_done) frames_sent <= frames_sent + 16'd1;

            // start+stop together in IDLE latches the stop so exactly one frame goes out.
            if (start_acc)               stop_seen <= stop;
            else if (state_nxt == IDLE)  stop_seen <= 1'b0;
            else if (stop && busy)       stop_seen <= 1'b1;

            if (frame_done)                          finish_q <= finish_now;
            else if (launch || (state_nxt == IDLE))  finish_q <= 1'b0;

            // Geometry is frozen per frame so the trailing blank and gap are unaffected by a boundary apply.
            if (launch) begin
                cur_width  <= sh_width;
                cur_height <= sh_height;
                cur_hblank <= sh_hblank;
                cur_period <= sh_period;
            end
        end
    end

    assign cfg_shape_ok = cfg_valid && (cfg_width != 12'd0) && (cfg_height != 12'd0);
    assign cfg_ok       = cfg_shape_ok && cfg_fits;
    assign apply        = start_acc || frame_done;

`ifdef TPG_SEQ_CFG_CHECK_EN
    logic [28:0] cfg_frame_len;
    assign cfg_frame_len = 29'(cfg_height) * (29'(cfg_width) + 29'(cfg_hblank));
    assign cfg_fits      = cfg_period > {3'b000, cfg_frame_len};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)          cfg_err <= 1'b0;
        else if (cfg_ok)       cfg_err <= 1'b0;
        else if (cfg_shape_ok) cfg_err <= 1'b1;
    end
`else
    assign cfg_fits = 1'b1;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_pending <= 1'b0;
            pd_width    <= 12'(DEF_WIDTH);
            pd_height   <= 12'(DEF_HEIGHT);
            pd_hblank   <= 16'(DEF_HBLANK);
            pd_period   <= 32'(DEF_PERIOD);
            pd_frames   <= 16'd0;
            sh_width    <= 12'(DEF_WIDTH);
            sh_height   <= 12'(DEF_HEIGHT);
            sh_hblank   <= 16'(DEF_HBLANK);
            sh_period   <= 32'(DEF_PERIOD);
            sh_frames   <= 16'd0;
        end else begin
            // A capture on the boundary cycle keeps pending set; the older values are applied now.
            if (cfg_ok) begin
                pd_width    <= cfg_width;
                pd_height   <= cfg_height;
                pd_hblank   <= cfg_hblank;
                pd_period   <= cfg_period;
                pd_frames   <= cfg_frames;
                cfg_pending <= 1'b1;
            end else if (apply) begin
                cfg_pending <= 1'b0;
            end
            if (apply && cfg_pending) begin
                sh_width  <= pd_width;
                sh_height <= pd_height;
                sh_hblank <= pd_hblank;
                sh_period <= pd_period;
                sh_frames <= pd_frames;
            end
        end
    end

endmodule

// File: tb/tb_tpg_frame_sequencer.sv
// tb/tb_tpg_frame_sequencer.sv - directed self-checking bench for tpg_frame_sequencer
module tb_tpg_frame_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start, stop, cfg_valid;
    logic [11:0] cfg_width, cfg_height;
    logic [15:0] cfg_hblank, cfg_frames;
    logic [31:0] cfg_period;
    logic        frame_valid, line_valid, frame_start, frame_done, busy, cfg_pending;
    logic [11:0] pixel_x, line_y;
    logic [15:0] frames_sent;
`ifdef TPG_SEQ_CFG_CHECK_EN
    logic        cfg_err;
`endif

    // Small default geometry: 3 lines of 6 pixels, 3 blank, period 40.
    tpg_frame_sequencer #(
        .DEF_WIDTH (6),
        .DEF_HEIGHT(3),
        .DEF_HBLANK(3),
        .DEF_PERIOD(40)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .cfg_hblank (cfg_hblank),
        .cfg_period (cfg_period),
        .cfg_frames (cfg_frames),
        .cfg_valid  (cfg_valid),
        .frame_valid(frame_valid),
        .line_valid (line_valid),
        .pixel_x    (pixel_x),
        .line_y     (line_y),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .busy       (busy),
        .cfg_pending(cfg_pending),
        .frames_sent(frames_sent)
`ifdef TPG_SEQ_CFG_CHECK_EN
        ,
        .cfg_err    (cfg_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc;
    always @(posedge clk) cyc <= cyc + 1;

    int checks;
    int errors;

    int          fs_q[$];
    int          fd_q[$];
    int          runs_q[$];
    int          lv_run;
    int          px_n;
    logic [31:0] px_pack, ly_pack;
    bit          busy_prev;
    int          busy_fall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        fs_q.delete();
        fd_q.delete();
        runs_q.delete();
        lv_run  = 0;
        px_n    = 0;
        px_pack = 32'd0;
        ly_pack = 32'd0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (frame_start) fs_q.push_back(cyc);
            if (frame_done)  fd_q.push_back(cyc);
            if (line_valid) begin
                lv_run++;
                if (px_n < 8) begin
                    px_pack = {px_pack[27:0], pixel_x[3:0]};
                    ly_pack = {ly_pack[27:0], line_y[3:0]};
                    px_n++;
                end
            end else if (lv_run != 0) begin
                runs_q.push_back(lv_run);
                lv_run = 0;
            end
            if (busy_prev && !busy) busy_fall = cyc;
            busy_prev = busy;
        end
    end

    // what: 0 busy low, 1 frame_start, 2 frame_done, 3 active pixel on line 1
    task automatic wait_for(input int what, input int limit, input string tag);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            @(negedge clk);
            case (what)
                0:       hit = !busy;
                1:       hit = frame_start;
                2:       hit = frame_done;
                default: hit = line_valid && (line_y == 12'd1);
            endcase
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    task automatic send_cfg(input int w, input int h, input int hb, input int per, input int fr);
        @(negedge clk);
        cfg_width  = 12'(w);
        cfg_height = 12'(h);
        cfg_hblank = 16'(hb);
        cfg_period = 32'(per);
        cfg_frames = 16'(fr);
        cfg_valid  = 1'b1;
        @(negedge clk);
        cfg_valid  = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
        cfg_width = 12'd0; cfg_height = 12'd0; cfg_hblank = 16'd0;
        cfg_period = 32'd0; cfg_frames = 16'd0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state and ignored inputs
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_outs", {frame_valid, line_valid, frame_start, frame_done, cfg_pending}, 32'd0);
        check("rst_coords", {pixel_x, line_y}, 32'd0);
        check("rst_frames_sent", 32'(frames_sent), 32'd0);
        send_cfg(0, 3, 2, 30, 0);
        check("zero_width_ignored", 32'(cfg_pending), 32'd0);
        pulse_stop();
        @(negedge clk);
        check("stop_in_idle", 32'(busy), 32'd0);

        // Default geometry, continuous, stop during the second frame
        clear_mon();
        pulse_start();
        check("t1_busy_rise", 32'(busy), 32'd1);
        check("t1_arm_no_lv", 32'(line_valid), 32'd0);
        @(negedge clk);
        check("t1_first_pixel", {frame_start, frame_valid, line_valid, 1'b0}, 32'hE);
        check("t1_first_xy", {pixel_x, line_y}, 32'd0);
        wait_for(1, 100, "t1_wait_fs2");
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_for(0, 100, "t1_wait_idle");
        repeat (2) @(negedge clk);
        check("t1_period", 32'(fs_q[1] - fs_q[0]), 32'd40);
        check("t1_done_ofs", 32'(fd_q[0] - fs_q[0]), 32'd23);
        check("t1_lines", 32'(runs_q.size()), 32'd6);
        check("t1_line_len", 32'(runs_q[0]), 32'd6);
        check("t1_frames_sent", 32'(frames_sent), 32'd2);

        // Two-frame burst
        clear_mon();
        send_cfg(4, 3, 2, 30, 2);
        check("t2_pending", 32'(cfg_pending), 32'd1);
        pulse_start();
        check("t2_pending_applied", 32'(cfg_pending), 32'd0);
        wait_for(0, 200, "t2_wait_idle");
        repeat (2) @(negedge clk);
        check("t2_nframes", 32'(fs_q.size()), 32'd2);
        check("t2_period", 32'(fs_q[1] - fs_q[0]), 32'd30);
        check("t2_done_ofs", 32'(fd_q[0] - fs_q[0]), 32'd15);
        check("t2_busy_fall", 32'(busy_fall - fd_q[1]), 32'd3);
        check("t2_lines", 32'(runs_q.size()), 32'd6);
        check("t2_frames_sent", 32'(frames_sent), 32'd2);

        // Continuous, stop on line 1 of frame 3
        clear_mon();
        send_cfg(4, 3, 2, 30, 0);
        pulse_start();
        for (int f = 0; f < 3; f++) wait_for(1, 100, "t3_wait_fs");
        wait_for(3, 50, "t3_wait_line1");
        pulse_stop();
        wait_for(0, 200, "t3_wait_idle");
        repeat (2) @(negedge clk);
        check("t3_frames_sent", 32'(frames_sent), 32'd3);
        check("t3_lines", 32'(runs_q.size()), 32'd9);
        check("t3_busy_fall", 32'(busy_fall - fd_q[2]), 32'd3);

        // Mid-frame reconfiguration lands on the boundary
        clear_mon();
        send_cfg(4, 3, 2, 30, 0);
        pulse_start();
        wait_for(1, 20, "t4_wait_fs1");
        wait_for(3, 20, "t4_wait_line1");
        send_cfg(8, 3, 2, 40, 0);
        check("t4_pending_mid", 32'(cfg_pending), 32'd1);
        wait_for(2, 50, "t4_wait_done");
        check("t4_pending_at_done", 32'(cfg_pending), 32'd1);
        @(negedge clk);
        check("t4_pending_after", 32'(cfg_pending), 32'd0);
        wait_for(1, 50, "t4_wait_fs2");
        pulse_stop();
        wait_for(0, 200, "t4_wait_idle");
        repeat (2) @(negedge clk);
        check("t4_period_old", 32'(fs_q[1] - fs_q[0]), 32'd30);
        check("t4_old_width", 32'(runs_q[2]), 32'd4);
        check("t4_new_width", 32'(runs_q[3]), 32'd8);
        check("t4_new_done_ofs", 32'(fd_q[1] - fs_q[1]), 32'd27);

        // Zero horizontal blank, single frame
        clear_mon();
        send_cfg(4, 2, 0, 20, 1);
        pulse_start();
        wait_for(0, 100, "t5_wait_idle");
        repeat (2) @(negedge clk);
        check("t5_runs", 32'(runs_q.size()), 32'd1);
        check("t5_run_len", 32'(runs_q[0]), 32'd8);
        check("t5_pixel_x", px_pack, 32'h01230123);
        check("t5_line_y", ly_pack, 32'h00001111);
        check("t5_frames_sent", 32'(frames_sent), 32'd1);

        // Asynchronous reset mid-line, then defaults again
        send_cfg(4, 3, 2, 30, 0);
        pulse_start();
        wait_for(2, 50, "t6_wait_done");
        wait_for(1, 50, "t6_wait_fs2");
        repeat (2) @(negedge clk);
        check("t6_pre_frames_sent", 32'(frames_sent), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_valids", {frame_valid, line_valid, busy}, 32'd0);
        check("t6_rst_counts", {pixel_x, frames_sent}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        clear_mon();
        pulse_start();
        wait_for(1, 20, "t6_wait_fs");
        pulse_stop();
        wait_for(0, 100, "t6_wait_idle");
        repeat (2) @(negedge clk);
        check("t6_def_lines", 32'(runs_q.size()), 32'd3);
        check("t6_def_width", 32'(runs_q[0]), 32'd6);
        check("t6_def_done_ofs", 32'(fd_q[0] - fs_q[0]), 32'd23);
        check("t6_frames_sent", 32'(frames_sent), 32'd1);

`ifdef TPG_SEQ_CFG_CHECK_EN
        send_cfg(4, 3, 2, 10, 0);
        check("chk_err_set", 32'(cfg_err), 32'd1);
        check("chk_not_captured", 32'(cfg_pending), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
